// File: rtl/spk_pkg.sv
// Shared definitions for the spike-vector assembler.
//   NEURONS_DEF - default spike-vector width
//   spk_aw()    - address width for a given neuron count
//   spk_cw()    - count width (holds 0..NEURONS inclusive)
//   spk_state_e - assembler FSM states
package spk_pkg;

  localparam int unsigned NEURONS_DEF = 32;

  // Floor at 1 bit so a single-neuron build still has a legal address port.
  function automatic int unsigned spk_aw(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  function automatic int unsigned spk_cw(input int unsigned n);
    return $clog2(n) + 1;
  endfunction

  // StAcc: accumulating beats; StStall: a finished timestep waits for the output register.
  typedef enum logic [0:0] {
    StAcc,
    StStall
  } spk_state_e;

endpackage

// File: rtl/spk_popcnt_inc.sv
// Sets one address bit in a spike vector and bumps the population count only when
// that bit was previously clear. Out-of-range addresses leave vector and count untouched.
// Ports:
//   vec_i  / cnt_i  - current accumulated vector and its population count
//   addr_i          - neuron address to set
//   vec_o  / cnt_o  - updated vector and count
module spk_popcnt_inc
  import spk_pkg::*;
#(
  parameter int unsigned NEURONS = NEURONS_DEF,
  localparam int unsigned AW = spk_aw(NEURONS),
  localparam int unsigned CW = spk_cw(NEURONS)
) (
  input  logic [NEURONS-1:0] vec_i,
  input  logic [CW-1:0]      cnt_i,
  input  logic [AW-1:0]      addr_i,
  output logic [NEURONS-1:0] vec_o,
  output logic [CW-1:0]      cnt_o
);

  logic [NEURONS-1:0] onehot;
  logic               hit;

  // Decoding only indices below NEURONS makes an out-of-range address an all-zero mask.
  always_comb begin
    onehot = '0;
    for (int unsigned i = 0; i < NEURONS; i++) begin
      onehot[i] = (addr_i == AW'(i));
    end
  end

  assign hit   = |(onehot & ~vec_i);
  assign vec_o = vec_i | onehot;
  assign cnt_o = cnt_i + CW'(hit);

endmodule

// File: rtl/spk_vec_assembler.sv
// Spike-vector assembler: collects a stream of spiking-neuron addresses per timestep
// into a bit vector plus population count, and hands it to a consumer on each done beat.
// Ports:
//   clk, rst            - clock (rising edge), asynchronous active-high reset
//   in_valid/in_ready   - address-stream handshake
//   in_addr, in_done    - neuron address; end-of-timestep marker (address ignored)
//   out_valid/out_ready - assembled-vector handshake
//   spk_vec, spk_cnt    - assembled vector and its number of set bits
//   order_err           - sticky non-increasing-address flag
// Build option: define SPK_ORDER_CHK_EN to enable the address-order checker;
// otherwise order_err is tied low.
module spk_vec_assembler
  import spk_pkg::*;
#(
  parameter int unsigned NEURONS = NEURONS_DEF,
  localparam int unsigned AW = spk_aw(NEURONS),
  localparam int unsigned CW = spk_cw(NEURONS)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [AW-1:0]      in_addr,
  input  logic               in_done,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [NEURONS-1:0] spk_vec,
  output logic [CW-1:0]      spk_cnt,
  output logic               order_err
);

  spk_state_e         state_q, state_d;
  logic [NEURONS-1:0] acc_vec_q, acc_vec_d;
  logic [CW-1:0]      acc_cnt_q, acc_cnt_d;
  logic [NEURONS-1:0] out_vec_q, out_vec_d;
  logic [CW-1:0]      out_cnt_q, out_cnt_d;
  logic               out_valid_q, out_valid_d;

  logic [NEURONS-1:0] inc_vec;
  logic [CW-1:0]      inc_cnt;
  logic               beat;

  spk_popcnt_inc #(
    .NEURONS(NEURONS)
  ) u_popcnt_inc (
    .vec_i (acc_vec_q),
    .cnt_i (acc_cnt_q),
    .addr_i(in_addr),
    .vec_o (inc_vec),
    .cnt_o (inc_cnt)
  );

  assign beat = in_valid && in_ready;

  always_comb begin
    state_d     = state_q;
    acc_vec_d   = acc_vec_q;
    acc_cnt_d   = acc_cnt_q;
    out_vec_d   = out_vec_q;
    out_cnt_d   = out_cnt_q;
    out_valid_d = out_valid_q;
    in_ready    = (state_q == StAcc);

    // A transfer empties the output register unless a load below refills it.
    if (out_valid_q && out_ready) begin
      out_valid_d = 1'b0;
    end

    unique case (state_q)
      StAcc: begin
        if (beat) begin
          if (in_done) begin
            if (!out_valid_q || out_ready) begin
              out_vec_d   = acc_vec_q;
              out_cnt_d   = acc_cnt_q;
              out_valid_d = 1'b1;
              acc_vec_d   = '0;
              acc_cnt_d   = '0;
            end else begin
              state_d = StStall;
            end
          end else begin
            acc_vec_d = inc_vec;
            acc_cnt_d = inc_cnt;
          end
        end
      end
      StStall: begin
        // out_valid_q is always set here, so out_ready alone means a transfer.
        if (out_ready) begin
          out_vec_d   = acc_vec_q;
          out_cnt_d   = acc_cnt_q;
          out_valid_d = 1'b1;
          acc_vec_d   = '0;
          acc_cnt_d   = '0;
          state_d     = StAcc;
        end
      end
      default: state_d = StAcc;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= StAcc;
      acc_vec_q   <= '0;
      acc_cnt_q   <= '0;
      out_vec_q   <= '0;
      out_cnt_q   <= '0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      acc_vec_q   <= acc_vec_d;
      acc_cnt_q   <= acc_cnt_d;
      out_vec_q   <= out_vec_d;
      out_cnt_q   <= out_cnt_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign spk_vec   = out_vec_q;
  assign spk_cnt   = out_cnt_q;
  assign out_valid = out_valid_q;

`ifdef SPK_ORDER_CHK_EN
  logic [AW-1:0] last_addr_q;
  logic          has_last_q;
  logic          order_err_q;

  // Tracker restarts on every done beat; the first address of a timestep is never an error.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last_addr_q <= '0;
      has_last_q  <= 1'b0;
      order_err_q <= 1'b0;
    end else if (beat) begin
      if (in_done) begin
        has_last_q <= 1'b0;
      end else begin
        if (has_last_q && (in_addr <= last_addr_q)) begin
          order_err_q <= 1'b1;
        end
        last_addr_q <= in_addr;
        has_last_q  <= 1'b1;
      end
    end
  end

  assign order_err = order_err_q;
`else
  assign order_err = 1'b0;
`endif

endmodule

// File: doc/spk_vec_assembler.md
SPK_VEC_ASSEMBLER -- requirements
Module: spk_vec_assembler

Interface
REQ-001 SHALL have parameter: NEURONS, 32, spike-vector width; address width AW = clog2(NEURONS), count width CW = clog2(NEURONS)+1.
REQ-002 SHALL have port: clk  input  1  sole clock, rising edge.
REQ-003 SHALL have port: rst  input  1  reset, asynchronous, active-high.
REQ-004 SHALL have port: in_valid  input  1  address-stream beat valid.
REQ-005 SHALL have port: in_ready  output  1  block accepts beat this cycle.
REQ-006 SHALL have port: in_addr  input  AW  spiking-neuron address.
REQ-007 SHALL have port: in_done  input  1  end-of-timestep marker; in_addr ignored on a done beat.
REQ-008 SHALL have port: out_valid  output  1  assembled vector available.
REQ-009 SHALL have port: out_ready  input  1  consumer accepts vector.
REQ-010 SHALL have port: spk_vec  output  NEURONS  assembled sparse spike vector, bit i = neuron i spiked.
REQ-011 SHALL have port: spk_cnt  output  CW  number of set bits in spk_vec.
REQ-012 SHALL have port: order_err  output  1  sticky address-order error flag.

Function
REQ-013 A beat SHALL transfer when in_valid && in_ready; an output SHALL transfer when out_valid && out_ready.
REQ-014 Datapath SHALL hold an accumulate register (acc_vec, acc_cnt) and an output register (spk_vec, spk_cnt, out_valid).
REQ-015 On an address beat, acc_vec[in_addr] SHALL be set next cycle; acc_cnt SHALL increment only if that bit was previously clear.
REQ-016 Addresses >= NEURONS (when NEURONS is not a power of two) SHALL be accepted and discarded without changing acc_vec or acc_cnt.
REQ-017 FSM states SHALL be ACC and STALL; reset state ACC.
REQ-018 In ACC, in_ready SHALL be 1.
REQ-019 In ACC, a done beat with output register empty or transferring that cycle SHALL copy acc to the output register, set out_valid, clear acc, and remain in ACC; latency from done beat to out_valid is 1 cycle.
REQ-020 In ACC, a done beat with out_valid=1 and out_ready=0 SHALL move to STALL, keeping acc intact.
REQ-021 In STALL, in_ready SHALL be 0; on the first cycle out_ready=1, the output SHALL transfer, acc SHALL be copied to the output register with out_valid held 1, acc SHALL clear, and the FSM SHALL return to ACC.
REQ-022 A done beat with empty acc SHALL produce spk_vec=0, spk_cnt=0 (empty timestep is a valid vector).
REQ-023 out_valid SHALL drop the cycle after an output transfer unless a new vector is loaded the same cycle.
REQ-024 spk_vec/spk_cnt SHALL stay stable while out_valid=1 and out_ready=0.
REQ-025 Throughput SHALL be one beat per cycle in ACC, with no bubbles between timesteps.

Reset
REQ-026 On rst: state ACC, acc_vec=0, acc_cnt=0, spk_vec=0, spk_cnt=0, out_valid=0, order_err=0, last-address tracker cleared; in_ready SHALL be 1 the first cycle after rst deasserts.
REQ-027 Reset mid-timestep SHALL discard the partial acc and any pending output; no vector emitted.

Configuration
REQ-028 With macro SPK_ORDER_CHK_EN defined, an address beat whose in_addr <= previous address in the same timestep SHALL set order_err (sticky until rst); the tracker resets on each done beat; the beat is still processed per REQ-015.
REQ-029 Without SPK_ORDER_CHK_EN, order_err SHALL be tied 0 and no tracker logic instantiated.

Structure
REQ-030 Shared package spk_pkg SHALL hold NEURONS default, AW/CW derivation functions, and the FSM state enum.
REQ-031 One sub-module spk_popcnt_inc (bit-already-set test and count increment) is natural; all else SHALL be in spk_vec_assembler.

Verification
REQ-032 Addresses 0,5,31 then done, out_ready=1 -> one cycle later spk_vec=0x80000021, spk_cnt=3, out_valid=1.
REQ-033 Addresses 7,7,7 then done -> spk_vec=0x00000080, spk_cnt=1.
REQ-034 Done alone right after reset -> spk_vec=0, spk_cnt=0, out_valid=1.
REQ-035 Two timesteps {1},{2} with out_ready=0 -> second done moves to STALL, in_ready=0; out_ready pulse -> 0x2 transfers, then 0x4 presented, in_ready=1.
REQ-036 rst asserted after addresses 3,4 before done -> all outputs 0; next done yields spk_vec=0.
REQ-037 SPK_ORDER_CHK_EN: addresses 9,4 -> order_err=1 and held; addresses 4,9 after rst -> order_err stays 0; without macro order_err=0 always.
